// File: rtl/address_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : address_queue_if
// Description : Dispatch-side and memory-side handshake bundle of the
//               in-order load/store address queue.
// Revision    : 1.0  initial release
// ============================================================================
interface address_queue_if #(
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_ADDRESS        = 32,
    parameter int BW_TAG            = 4,
    parameter int AQ_LENGTH         = 10
);
    localparam int CW = $clog2(AQ_LENGTH + 1);

    logic                         i_disp_valid;
    logic                         i_disp_ready;
    logic                         i_disp_opcode;
    logic [BW_TAG-1:0]            i_disp_tag;
    logic [BW_ADDRESS-1:0]        i_disp_rwaddr;
    logic [BW_PROCESSOR_DATA-1:0] i_disp_wdata;

    logic                         o_lsrsv_valid;
    logic                         o_lsrsv_ready;
    logic                         o_lsrsv_opcode;
    logic [BW_TAG-1:0]            o_lsrsv_tag;
    logic [BW_ADDRESS-1:0]        o_lsrsv_rwaddr;
    logic [BW_PROCESSOR_DATA-1:0] o_lsrsv_wdata;
    logic                         o_lsrsv_load_forwarding_valid;
    logic [BW_PROCESSOR_DATA-1:0] o_lsrsv_load_forwarding_data;
    logic [CW-1:0]                o_count;

    // Dispatch and memory-unit side (testbench / surrounding pipeline)
    modport master (
        output i_disp_valid, i_disp_opcode, i_disp_tag, i_disp_rwaddr, i_disp_wdata,
        input  i_disp_ready,
        output o_lsrsv_ready,
        input  o_lsrsv_valid, o_lsrsv_opcode, o_lsrsv_tag, o_lsrsv_rwaddr,
        input  o_lsrsv_wdata, o_lsrsv_load_forwarding_valid,
        input  o_lsrsv_load_forwarding_data, o_count
    );

    // The queue itself
    modport slave (
        input  i_disp_valid, i_disp_opcode, i_disp_tag, i_disp_rwaddr, i_disp_wdata,
        output i_disp_ready,
        input  o_lsrsv_ready,
        output o_lsrsv_valid, o_lsrsv_opcode, o_lsrsv_tag, o_lsrsv_rwaddr,
        output o_lsrsv_wdata, o_lsrsv_load_forwarding_valid,
        output o_lsrsv_load_forwarding_data, o_count
    );
endinterface
`default_nettype wire

// File: rtl/address_queue.sv
`default_nettype none
// ============================================================================
// Module      : address_queue
// Description : In-order circular load/store address queue. Defining
//               ADDRESS_QUEUE_STORE_FORWARD_EN adds a store history that
//               forwards data to a load waiting at the head.
// Revision    : 1.0  initial release
// ============================================================================
module address_queue #(
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_ADDRESS        = 32,
    parameter int BW_TAG            = 4,
    parameter int AQ_LENGTH         = 10,
    parameter int NUM_STORE_HISTORY = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    address_queue_if.slave  bus
);
    localparam int CW = $clog2(AQ_LENGTH + 1);
    localparam int PW = $clog2(AQ_LENGTH);

    localparam logic [CW-1:0] c_DEPTH    = CW'(AQ_LENGTH);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] c_PTR_LAST = PW'(AQ_LENGTH - 1);
    localparam logic [PW-1:0] c_PTR_ONE  = PW'(1);

    logic [PW-1:0]                r_rd_ptr;
    logic [PW-1:0]                r_wr_ptr;
    logic [CW-1:0]                r_count;

    logic                         r_opcode [AQ_LENGTH];
    logic [BW_TAG-1:0]            r_tag    [AQ_LENGTH];
    logic [BW_ADDRESS-1:0]        r_addr   [AQ_LENGTH];
    logic [BW_PROCESSOR_DATA-1:0] r_wdata  [AQ_LENGTH];

    logic                         w_ready;
    logic                         w_valid;
    logic                         w_enq;
    logic                         w_deq;
    logic                         w_head_opcode;
    logic [BW_ADDRESS-1:0]        w_head_addr;
    logic [BW_PROCESSOR_DATA-1:0] w_head_wdata;

    // Ready depends only on occupancy, so a full queue never accepts even
    // when the head is leaving in the same cycle.
    assign w_ready = (r_count < c_DEPTH);
    assign w_valid = (r_count != '0);
    assign w_enq   = bus.i_disp_valid && w_ready;
    assign w_deq   = w_valid && bus.o_lsrsv_ready;

    assign w_head_opcode = r_opcode[r_rd_ptr];
    assign w_head_addr   = r_addr[r_rd_ptr];
    assign w_head_wdata  = r_wdata[r_rd_ptr];

    assign bus.i_disp_ready   = w_ready;
    assign bus.o_lsrsv_valid  = w_valid;
    assign bus.o_lsrsv_opcode = w_head_opcode;
    assign bus.o_lsrsv_tag    = r_tag[r_rd_ptr];
    assign bus.o_lsrsv_rwaddr = w_head_addr;
    assign bus.o_lsrsv_wdata  = w_head_wdata;
    assign bus.o_count        = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < AQ_LENGTH; i++) begin
                r_opcode[i] <= 1'b0;
                r_tag[i]    <= '0;
                r_addr[i]   <= '0;
                r_wdata[i]  <= '0;
            end
        end else if (w_enq) begin
            r_opcode[r_wr_ptr] <= bus.i_disp_opcode;
            r_tag[r_wr_ptr]    <= bus.i_disp_tag;
            r_addr[r_wr_ptr]   <= bus.i_disp_rwaddr;
            r_wdata[r_wr_ptr]  <= bus.i_disp_wdata;
        end
    end

`ifdef ADDRESS_QUEUE_STORE_FORWARD_EN
    // Slot 0 holds the most recently dequeued store.
    logic                         r_hist_valid [NUM_STORE_HISTORY];
    logic [BW_ADDRESS-1:0]        r_hist_addr  [NUM_STORE_HISTORY];
    logic [BW_PROCESSOR_DATA-1:0] r_hist_data  [NUM_STORE_HISTORY];
    logic [NUM_STORE_HISTORY-1:0] w_hit;
    logic                         w_any_hit;
    logic [BW_PROCESSOR_DATA-1:0] w_hit_data;
    logic                         w_fwd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STORE_HISTORY; i++) begin
                r_hist_valid[i] <= 1'b0;
                r_hist_addr[i]  <= '0;
                r_hist_data[i]  <= '0;
            end
        end else if (w_deq && w_head_opcode) begin
            r_hist_valid[0] <= 1'b1;
            r_hist_addr[0]  <= w_head_addr;
            r_hist_data[0]  <= w_head_wdata;
            for (int i = 1; i < NUM_STORE_HISTORY; i++) begin
                r_hist_valid[i] <= r_hist_valid[i-1];
                r_hist_addr[i]  <= r_hist_addr[i-1];
                r_hist_data[i]  <= r_hist_data[i-1];
            end
        end
    end

    for (genvar g = 0; g < NUM_STORE_HISTORY; g++) begin : g_hist_cmp
        assign w_hit[g] = r_hist_valid[g] && (r_hist_addr[g] == w_head_addr);
    end

    // Walk from oldest to youngest so the youngest matching slot wins.
    always_comb begin
        w_hit_data = '0;
        for (int i = NUM_STORE_HISTORY - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_data = r_hist_data[i];
            end
        end
    end

    assign w_any_hit   = |w_hit;
    assign w_fwd_valid = w_valid && !w_head_opcode && w_any_hit;

    assign bus.o_lsrsv_load_forwarding_valid = w_fwd_valid;
    assign bus.o_lsrsv_load_forwarding_data  = w_fwd_valid ? w_hit_data : '0;
`else
    assign bus.o_lsrsv_load_forwarding_valid = 1'b0;
    assign bus.o_lsrsv_load_forwarding_data  = '0;
`endif

endmodule
`default_nettype wire
